// File: rtl/hpu_intr_arb.sv
// Core-side interrupt arbiter: registers CLINT pending bits, qualifies them with mie/gie,
// picks one by fixed priority and runs a req/ack handshake into the commit stage.
module hpu_intr_arb #(
  parameter int unsigned INTR_NUM  = 32,
  parameter int unsigned CAUSE_WTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INTR_NUM-1:0]  clint_ctrl__intr_act_i,
  input  logic [INTR_NUM-1:0]  csr_ctrl__mie_i,
  input  logic                 csr_ctrl__gie_i,
  input  logic                 ctrl_intr__block_i,
  input  logic                 ctrl_intr__ack_i,
  output logic                 intr_ctrl__req_o,
  output logic [CAUSE_WTH-1:0] intr_ctrl__cause_o,
  output logic                 intr_ctrl__wake_o
);

  localparam int unsigned ExtW = 1 << CAUSE_WTH;
  localparam int          Top  = INTR_NUM - 1;

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e                 state_q;
  logic [INTR_NUM-1:0]    pend_q;
  logic                   req_q;
  logic                   wake_q;
  logic [CAUSE_WTH-1:0]   cause_q;

  logic [INTR_NUM-1:0]    eligible;
  logic [ExtW-1:0]        elig_ext;
  logic                   sel_vld;
  logic [CAUSE_WTH-1:0]   sel_idx;
  logic                   cause_elig;

  assign eligible   = pend_q & csr_ctrl__mie_i;
  assign elig_ext   = ExtW'(eligible);
  assign cause_elig = elig_ext[cause_q];

  // Platform interrupts scan high to low so the lowest index is left standing;
  // the three machine-level sources then override in reverse priority order.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = Top; i >= 16; i--) begin
      if (eligible[i]) begin
        sel_vld = 1'b1;
        sel_idx = CAUSE_WTH'(i);
      end
    end
    if (eligible[7]) begin
      sel_vld = 1'b1;
      sel_idx = CAUSE_WTH'(7);
    end
    if (eligible[3]) begin
      sel_vld = 1'b1;
      sel_idx = CAUSE_WTH'(3);
    end
    if (eligible[11]) begin
      sel_vld = 1'b1;
      sel_idx = CAUSE_WTH'(11);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      pend_q  <= '0;
      req_q   <= 1'b0;
      wake_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      pend_q <= clint_ctrl__intr_act_i;
      wake_q <= |eligible;
      case (state_q)
        StIdle: begin
          if (sel_vld && csr_ctrl__gie_i && !ctrl_intr__block_i) begin
            cause_q <= sel_idx;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          // Ack has precedence over withdraw; cause stays frozen while requesting.
          if (ctrl_intr__ack_i) begin
            req_q   <= 1'b0;
            state_q <= StHold;
          end else if (!cause_elig || !csr_ctrl__gie_i || ctrl_intr__block_i) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        StHold: begin
          // One quiet cycle lets the trap's mstatus.MIE update take effect.
          req_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign intr_ctrl__req_o   = req_q;
  assign intr_ctrl__cause_o = cause_q;
  assign intr_ctrl__wake_o  = wake_q;

endmodule

// File: tb/tb_hpu_intr_arb.sv
// Directed bench for hpu_intr_arb: hand-computed expectations checked with immediate assertions.
module tb_hpu_intr_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] act;
  logic [31:0] mie;
  logic        gie;
  logic        block;
  logic        ack;
  logic        req;
  logic [4:0]  cause;
  logic        wake;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  hpu_intr_arb #(
    .INTR_NUM  (32),
    .CAUSE_WTH (5)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .clint_ctrl__intr_act_i (act),
    .csr_ctrl__mie_i        (mie),
    .csr_ctrl__gie_i        (gie),
    .ctrl_intr__block_i     (block),
    .ctrl_intr__ack_i       (ack),
    .intr_ctrl__req_o       (req),
    .intr_ctrl__cause_o     (cause),
    .intr_ctrl__wake_o      (wake)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    act   = '0;
    mie   = '0;
    gie   = 1'b0;
    block = 1'b0;
    ack   = 1'b0;
    #12;
    chk("rst_req", req, 0);
    chk("rst_cause", cause, 0);
    chk("rst_wake", wake, 0);
    rst_i = 1'b1;
    tick(2);

    // MTI only
    act = 32'h80; mie = 32'h80; gie = 1'b1;
    tick(1);
    chk("mti_c1_req", req, 0);
    tick(1);
    chk("mti_c2_req", req, 1);
    chk("mti_c2_cause", cause, 7);
    chk("mti_c2_wake", wake, 1);
    tick(1);
    chk("mti_c3_req", req, 1);
    ack = 1'b1;
    tick(1);
    chk("mti_hold_req", req, 0);
    ack = 1'b0; gie = 1'b0;
    tick(1);
    chk("mti_c6_req", req, 0);
    tick(1);
    chk("mti_c7_req", req, 0);
    chk("mti_c7_wake", wake, 1);
    act = '0; mie = '1;
    tick(2);

    // Priority 11 > 3 > 7 > 20
    act = 32'h0010_0888; gie = 1'b1;
    tick(2);
    chk("prio_req", req, 1);
    chk("prio_cause11", cause, 11);
    ack = 1'b1; act = 32'h0010_0088;
    tick(1);
    chk("prio_hold_req", req, 0);
    ack = 1'b0;
    tick(1);
    chk("prio_idle_req", req, 0);
    tick(1);
    chk("prio_rereq", req, 1);
    chk("prio_cause3", cause, 3);
    ack = 1'b1; act = '0;
    tick(1);
    ack = 1'b0;
    tick(2);
    chk("prio_clear_req", req, 0);

    // Frozen cause and withdraw
    act = 32'h80;
    tick(2);
    chk("frz_cause7", cause, 7);
    act = 32'h880;
    tick(3);
    chk("frz_req", req, 1);
    chk("frz_cause_kept", cause, 7);
    act = 32'h800;
    tick(1);
    chk("wd_req_still", req, 1);
    tick(1);
    chk("wd_req_drop", req, 0);
    tick(1);
    chk("wd_rereq", req, 1);
    chk("wd_cause11", cause, 11);

    // Block and ack together: ack wins
    block = 1'b1; ack = 1'b1;
    tick(1);
    chk("race_req", req, 0);
    block = 1'b0; ack = 1'b0; gie = 1'b0;
    tick(2);
    chk("race_no_rereq", req, 0);
    ack = 1'b1;
    tick(1);
    chk("ack_idle_ignored", req, 0);
    ack = 1'b0;

    // Gating by gie and mask
    act = '0; mie = '0;
    tick(2);
    chk("gate_wake_clear", wake, 0);
    act = 32'h1_0000; mie = 32'h1_0000;
    tick(1);
    chk("gate_wake_c1", wake, 0);
    tick(1);
    chk("gate_wake_c2", wake, 1);
    chk("gate_req_gie0", req, 0);
    mie = '0;
    tick(1);
    chk("gate_wake_mask", wake, 0);
    gie = 1'b1; act = 32'h888; mie = ~32'h888;
    tick(2);
    chk("mask_m_req", req, 0);
    chk("mask_m_wake", wake, 0);
    act = 32'h20; mie = '1;
    tick(2);
    chk("nonsel_req", req, 0);
    chk("nonsel_wake", wake, 1);

    // Block in IDLE and in REQ
    act = 32'h8; block = 1'b1;
    tick(2);
    chk("blk_idle_req", req, 0);
    block = 1'b0;
    tick(1);
    chk("blk_rel_req", req, 1);
    chk("blk_rel_cause", cause, 3);
    block = 1'b1;
    tick(1);
    chk("blk_req_drop", req, 0);
    tick(1);
    chk("blk_req_held", req, 0);
    block = 1'b0;
    tick(1);
    chk("blk_rereq", req, 1);

    // Asynchronous reset mid-request
    rst_i = 1'b0;
    #2;
    chk("arst_req", req, 0);
    chk("arst_cause", cause, 0);
    chk("arst_wake", wake, 0);
    #2;
    rst_i = 1'b1;
    tick(1);
    chk("arst_rel_c1", req, 0);
    tick(1);
    chk("arst_rel_c2", req, 1);
    chk("arst_rel_cause", cause, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hpu_intr_arb.md
Name: hpu_intr_arb

Overview:
- Core-side consumer of the CLINT interrupt-pending vector.
- Registers the pending vector and qualifies it with the CSR enable mask (mie) and the global enable (mstatus.MIE).
- Selects one interrupt by fixed priority and drives a request/acknowledge handshake into the commit/trap stage, holding the cause stable until the trap is taken or the request is withdrawn.
- Also drives a WFI wake indication.

Parameters:
- INTR_NUM, 32, width of the pending/enable vectors; matches the mip/mie layout.
- CAUSE_WTH, 5, width of the cause index output; must satisfy 2**CAUSE_WTH >= INTR_NUM.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  reset, asynchronous, active-low
- clint_ctrl__intr_act_i  input  INTR_NUM  pending bits from CLINT (level)
- csr_ctrl__mie_i  input  INTR_NUM  per-interrupt enable mask
- csr_ctrl__gie_i  input  1  mstatus.MIE global enable
- ctrl_intr__block_i  input  1  pipeline cannot accept a trap this cycle (debug/flush)
- ctrl_intr__ack_i  input  1  trap taken for the presented cause
- intr_ctrl__req_o  output  1  interrupt request to commit stage
- intr_ctrl__cause_o  output  CAUSE_WTH  index of the requested interrupt (mcause low bits)
- intr_ctrl__wake_o  output  1  any enabled interrupt pending, gie ignored (WFI wake)

Behaviour:
- Reset: all outputs 0; state IDLE; pending register 0; cause register 0.
- Stage 1: pend_q <= clint_ctrl__intr_act_i every cycle. eligible = pend_q & csr_ctrl__mie_i.
- intr_ctrl__wake_o <= |eligible. Registered, so there is 1 cycle after pend_q.
- Priority, highest first:
  - bit 11 (MEI), then bit 3 (MSI), then bit 7 (MTI);
  - then bits 16..INTR_NUM-1, lowest index first;
  - all other bits are never selected and never raise a request.
- sel_vld = any selectable bit of eligible set.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: if sel_vld & gie & ~block, then cause <= selected index, req <= 1, go to REQ.
  - REQ, checked in this order:
    - ack=1: req <= 0, go to HOLD. Ack wins over any simultaneous withdraw.
    - selected bit no longer eligible, or gie=0: req <= 0, go to IDLE (withdraw).
    - block=1: req <= 0, go to IDLE.
    - otherwise hold. The cause is frozen; a higher-priority arrival does not preempt.
  - HOLD: lasts exactly 1 cycle, so the CSR update of gie can land. req stays 0; then go to IDLE.
- Latency: CLINT bit rises at cycle N, pend_q at N+1, req/cause at N+2 when enabled and unblocked.
- Re-request after ack: at the earliest 2 cycles after ack, and only if gie is still 1.
- intr_ctrl__cause_o is only valid while req=1; it holds its last value otherwise.
- ack while not in REQ is ignored.
- Reset mid-REQ: req drops immediately (asynchronous) and the FSM returns to IDLE.
- Mask bits of 0 on MSI/MTI/MEI fully suppress both req and wake.

Test Plan:
- MTI only: act[7]=1, mie[7]=1, gie=1 at cycle 0 -> req=1, cause=7 at cycle 2; ack at cycle 4 -> req=0 at cycle 5; HOLD at 5; gie=0 from 5 -> no re-request.
- Priority: act[3], act[7], act[11], act[20] all set, all enabled -> cause=11. After ack and clearing act[11], with gie kept 1 -> cause=3 two cycles later.
- Frozen cause: in REQ with cause=7, raise act[11] -> cause stays 7 until ack. Drop act[7] instead -> req falls the cycle after eligible drops, then re-requests cause=11.
- Gating: gie=0, act[16]=1, mie[16]=1 -> req stays 0, wake=1 at cycle 2. mie[16]=0 -> wake=0.
- Block/ack race: in REQ assert block=1 and ack=1 in the same cycle -> ack wins, HOLD entered, req=0.
- Reset: assert rst_i low while req=1 -> req=0, cause=0, wake=0 immediately. Release with inputs still active -> req again 2 cycles after release.
